div_seq_ctrl: RTL and testbench

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 30 +++
 rtl/div_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_div_seq_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and widths.
package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: the dividend bits are shifted out of
// quot_in into the partial remainder while quotient bits are shifted in.
module div_step #(
    parameter int DIV_W = 32
) (
    input  logic [DIV_W-1:0] rem_in,
    input  logic [DIV_W-1:0] quot_in,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] rem_out,
    output logic [DIV_W-1:0] quot_out
);

    logic [DIV_W:0]   shifted;
    logic [DIV_W-1:0] diff;

    // NOTE: every branch assigns every output, so this stays pure logic (no latch).
    always_comb begin
        shifted = {rem_in, quot_in[DIV_W-1]};
        // When the subtraction succeeds the result is below the divisor, so DIV_W bits suffice.
        diff    = shifted[DIV_W-1:0] - divisor;
        if (shifted >= {1'b0, divisor}) begin
            rem_out  = diff;
            quot_out = {quot_in[DIV_W-2:0], 1'b1};
        end else begin
            rem_out  = shifted[DIV_W-1:0];
            quot_out = {quot_in[DIV_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU unit with EX-stall control; define DIV_EARLY_OUT_EN to
// finish divide-by-zero and |dividend| < |divisor| in a single cycle.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             es_div_req,
    input  logic             es_div_signed,
    input  logic [DIV_W-1:0] es_div_src1,
    input  logic [DIV_W-1:0] es_div_src2,
    input  logic             ms_allowin,
    input  logic             flush,
    output logic             div_stop,
    output logic             div_busy,
    output logic             div_done,
    output logic [DIV_W-1:0] div_quot,
    output logic [DIV_W-1:0] div_rem
);

    div_state_t           state;
    logic [DIV_CNT_W-1:0] cnt;
    logic [DIV_W-1:0]     part_rem, part_quot, divisor_mag;
    logic                 quot_neg, rem_neg;
    logic [DIV_W-1:0]     step_rem, step_quot;

    logic             src1_neg, src2_neg;
    logic [DIV_W-1:0] src1_mag, src2_mag;

    assign src1_neg = es_div_signed & es_div_src1[DIV_W-1];
    assign src2_neg = es_div_signed & es_div_src2[DIV_W-1];
    assign src1_mag = src1_neg ? -es_div_src1 : es_div_src1;
    assign src2_mag = src2_neg ? -es_div_src2 : es_div_src2;

`ifdef DIV_EARLY_OUT_EN
    logic             early_out;
    logic [DIV_W-1:0] early_quot;
    // Divide-by-zero gives an all-ones magnitude, which sign-fixes to +1 when the signs differ.
    assign early_out  = (src2_mag == '0) || (src1_mag < src2_mag);
    assign early_quot = (src2_mag != '0) ? '0 : ((src1_neg ^ src2_neg) ? DIV_W'(1) : '1);
`else
    logic             early_out;
    logic [DIV_W-1:0] early_quot;
    assign early_out  = 1'b0;
    assign early_quot = '0;
`endif

    div_step #(.DIV_W(DIV_W)) u_step (
        .rem_in  (part_rem),
        .quot_in (part_quot),
        .divisor (divisor_mag),
        .rem_out (step_rem),
        .quot_out(step_quot)
    );

    assign div_stop = !reset && !flush &&
                      (((state == IDLE) && es_div_req) || (state == BUSY));

    // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            part_rem    <= '0;
            part_quot   <= '0;
            divisor_mag <= '0;
            quot_neg    <= 1'b0;
            rem_neg     <= 1'b0;
            div_quot    <= '0;
            div_rem     <= '0;
            div_busy    <= 1'b0;
            div_done    <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            div_busy <= 1'b0;
            div_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (es_div_req) begin
                        quot_neg <= src1_neg ^ src2_neg;
                        rem_neg  <= src1_neg;
                        if (early_out) begin
                            state    <= DONE;
                            div_done <= 1'b1;
                            div_quot <= early_quot;
                            div_rem  <= es_div_src1;
                        end else begin
                            state       <= BUSY;
                            div_busy    <= 1'b1;
                            part_rem    <= '0;
                            part_quot   <= src1_mag;
                            divisor_mag <= src2_mag;
                            cnt         <= DIV_CNT_W'(DIV_W - 1);
                        end
                    end
                end
                BUSY: begin
                    part_rem  <= step_rem;
                    part_quot <= step_quot;
                    if (cnt == '0) begin
                        state    <= DONE;
                        div_busy <= 1'b0;
                        div_done <= 1'b1;
                        div_quot <= quot_neg ? -step_quot : step_quot;
                        div_rem  <= rem_neg ? -step_rem : step_rem;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (ms_allowin) begin
                        state    <= IDLE;
                        div_done <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    div_busy <= 1'b0;
                    div_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl; follows DIV_EARLY_OUT_EN for expected latency.
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         es_div_req, es_div_signed;
    logic [W-1:0] es_div_src1, es_div_src2;
    logic         ms_allowin, flush;
    logic         div_stop, div_busy, div_done;
    logic [W-1:0] div_quot, div_rem;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    div_seq_ctrl #(.DIV_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .es_div_req   (es_div_req),
        .es_div_signed(es_div_signed),
        .es_div_src1  (es_div_src1),
        .es_div_src2  (es_div_src2),
        .ms_allowin   (ms_allowin),
        .flush        (flush),
        .div_stop     (div_stop),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .div_quot     (div_quot),
        .div_rem      (div_rem)
    );

    always #5 clk = ~clk;

    // Reference: divide magnitudes with / and %, then apply the MIPS sign rules.
    function automatic void ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        logic an, bn;
        logic [W-1:0] am, bm, qm, rm;
        an = sgn && a[W-1];
        bn = sgn && b[W-1];
        am = an ? (32'd0 - a) : a;
        bm = bn ? (32'd0 - b) : b;
        if (bm == 0) begin
            qm = '1;
            rm = am;
        end else begin
            qm = am / bm;
            rm = am % bm;
        end
        q = (an ^ bn) ? (32'd0 - qm) : qm;
        r = an ? (32'd0 - rm) : rm;
    endfunction

    function automatic int ref_lat(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] am, bm;
        am = (sgn && a[W-1]) ? (32'd0 - a) : a;
        bm = (sgn && b[W-1]) ? (32'd0 - b) : b;
`ifdef DIV_EARLY_OUT_EN
        if (bm == 0 || am < bm) return 1;
`endif
        return W + 1;
    endfunction

    // Called just after a rising edge in the request cycle; returns at the falling
    // edge of the first DONE cycle (lat = -1 if it never arrives).
    task automatic wait_done(output int lat, output int stop_cnt, output int busy_cnt);
        lat = 0;
        stop_cnt = 0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (div_done) break;
            if (div_stop) stop_cnt++;
            if (div_busy) busy_cnt++;
            @(posedge clk);
            #1;
            es_div_req = 1'b0;
            lat++;
            if (lat > 100) begin
                lat = -1;
                break;
            end
        end
    endtask

    task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output int lat, output int stop_cnt, output int busy_cnt);
        es_div_req    = 1'b1;
        es_div_signed = sgn;
        es_div_src1   = a;
        es_div_src2   = b;
        wait_done(lat, stop_cnt, busy_cnt);
        q = div_quot;
        r = div_rem;
    endtask

    task automatic release_done();
        ms_allowin = 1'b1;
        @(posedge clk);
        #1;
        ms_allowin = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        es_div_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({div_stop, div_busy, div_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {div_stop, div_busy, div_done});
        end
        checks++;
        if ({div_quot, div_rem} !== {W{2'b00}}) begin
            errors++;
            $display("FAIL reset_results got %h/%h want 0/0", div_quot, div_rem);
        end
        es_div_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last_q = '0;
        last_r = '0;
        @(posedge clk);
        #1;
        checks++;
        if ({div_stop, div_busy, div_done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 000", {div_stop, div_busy, div_done});
        end
    endtask

    task automatic test_divu_basic();
        logic [W-1:0] q, r;
        int lat, sc, bc;
        do_div(1'b0, 32'd100, 32'd7, q, r, lat, sc, bc);
        checks++;
        if ({q, r} !== {32'd14, 32'd2}) begin
            errors++;
            $display("FAIL divu_100_7 got q=%0d r=%0d want q=14 r=2", q, r);
        end
        checks++;
        if (lat !== 33 || sc !== 33) begin
            errors++;
            $display("FAIL divu_100_7_latency got lat=%0d stop=%0d want 33/33", lat, sc);
        end
        checks++;
        if (bc !== 32) begin
            errors++;
            $display("FAIL divu_100_7_busy got %0d want 32", bc);
        end
        checks++;
        if (div_stop !== 1'b0) begin
            errors++;
            $display("FAIL stop_in_done got %b want 0", div_stop);
        end
        last_q = 32'd14;
        last_r = 32'd2;
        release_done();
    endtask

    task automatic test_signed();
        logic [W-1:0] ta [5] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100};
        logic [W-1:0] tb [5] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        logic [W-1:0] eq [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'hFFFF_FFF2};
        logic [W-1:0] er [5] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd2};
        logic [W-1:0] q, r;
        int lat, sc, bc;
        for (int i = 0; i < 5; i++) begin
            do_div(1'b1, ta[i], tb[i], q, r, lat, sc, bc);
            checks++;
            if ({q, r} !== {eq[i], er[i]}) begin
                errors++;
                $display("FAIL div_signed_%0d got q=%h r=%h want q=%h r=%h", i, q, r, eq[i], er[i]);
            end
            checks++;
            if (lat !== ref_lat(1'b1, ta[i], tb[i])) begin
                errors++;
                $display("FAIL div_signed_%0d_latency got %0d want %0d", i, lat, ref_lat(1'b1, ta[i], tb[i]));
            end
            last_q = eq[i];
            last_r = er[i];
            release_done();
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r;
        int lat, sc, bc, want_lat;
        want_lat = ref_lat(1'b0, 32'd5, 32'd0);
        do_div(1'b0, 32'd5, 32'd0, q, r, lat, sc, bc);
        checks++;
        if ({q, r} !== {32'hFFFF_FFFF, 32'd5}) begin
            errors++;
            $display("FAIL divu_5_0 got q=%h r=%h want q=ffffffff r=5", q, r);
        end
        checks++;
        if (lat !== want_lat || sc !== want_lat) begin
            errors++;
            $display("FAIL divu_5_0_latency got lat=%0d stop=%0d want %0d", lat, sc, want_lat);
        end
        release_done();
        do_div(1'b1, 32'hFFFF_FFFB, 32'd0, q, r, lat, sc, bc);
        checks++;
        if ({q, r} !== {32'd1, 32'hFFFF_FFFB}) begin
            errors++;
            $display("FAIL div_m5_0 got q=%h r=%h want q=1 r=fffffffb", q, r);
        end
        last_q = 32'd1;
        last_r = 32'hFFFF_FFFB;
        release_done();
    endtask

    task automatic test_flush();
        bit saw_done = 1'b0;
        bit moved = 1'b0;
        // Flush together with a request in IDLE must not stall or start.
        es_div_req = 1'b1;
        es_div_signed = 1'b0;
        es_div_src1 = 32'd100;
        es_div_src2 = 32'd7;
        flush = 1'b1;
        #1;
        checks++;
        if (div_stop !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_stop got %b want 0", div_stop);
        end
        @(posedge clk);
        #1;
        es_div_req = 1'b0;
        flush = 1'b0;
        checks++;
        if (div_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_no_start got busy=%b want 0", div_busy);
        end
        // Flush in the tenth BUSY cycle.
        es_div_req = 1'b1;
        @(posedge clk);
        #1;
        es_div_req = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        checks++;
        if ({div_stop, div_busy} !== 2'b01) begin
            errors++;
            $display("FAIL flush_busy_stop got stop,busy=%b want 01", {div_stop, div_busy});
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if ({div_stop, div_busy, div_done} !== 3'b000) begin
            errors++;
            $display("FAIL flush_to_idle got %b want 000", {div_stop, div_busy, div_done});
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_done) saw_done = 1'b1;
            if ({div_quot, div_rem} !== {last_q, last_r}) moved = 1'b1;
        end
        checks++;
        if (saw_done || moved) begin
            errors++;
            $display("FAIL flush_aftermath got done_seen=%b outputs_changed=%b want 0/0", saw_done, moved);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q, r;
        int lat, sc, bc;
        do_div(1'b0, 32'd1000, 32'd10, q, r, lat, sc, bc);
        checks++;
        if ({q, r} !== {32'd100, 32'd0}) begin
            errors++;
            $display("FAIL divu_1000_10 got q=%0d r=%0d want 100/0", q, r);
        end
        es_div_req = 1'b1;
        es_div_signed = 1'b0;
        es_div_src1 = 32'd9;
        es_div_src2 = 32'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({div_done, div_busy, div_stop, div_quot, div_rem} !== {3'b100, 32'd100, 32'd0}) begin
                errors++;
                $display("FAIL done_hold_%0d got done,busy,stop=%b q=%0d r=%0d want 100 100/0", i,
                         {div_done, div_busy, div_stop}, div_quot, div_rem);
            end
        end
        release_done();
        wait_done(lat, sc, bc);
        checks++;
        if ({div_quot, div_rem} !== {32'd3, 32'd0} || lat !== 33) begin
            errors++;
            $display("FAIL divu_9_3_b2b got q=%0d r=%0d lat=%0d want 3/0 lat 33", div_quot, div_rem, lat);
        end
        last_q = 32'd3;
        last_r = 32'd0;
        release_done();
    endtask

    task automatic test_reset_mid_busy();
        logic [W-1:0] q, r;
        int lat, sc, bc;
        es_div_req = 1'b1;
        es_div_signed = 1'b0;
        es_div_src1 = 32'd100;
        es_div_src2 = 32'd7;
        @(posedge clk);
        #1;
        es_div_req = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({div_stop, div_busy, div_done, div_quot, div_rem} !== {3'b000, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_async got flags=%b q=%h r=%h want 000 0/0",
                     {div_stop, div_busy, div_done}, div_quot, div_rem);
        end
        last_q = '0;
        last_r = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({div_busy, div_done, div_quot, div_rem} !== {2'b00, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_abandon got busy,done=%b q=%h r=%h want 00 0/0",
                     {div_busy, div_done}, div_quot, div_rem);
        end
        @(posedge clk);
        #1;
        do_div(1'b0, 32'd9, 32'd3, q, r, lat, sc, bc);
        checks++;
        if ({q, r} !== {32'd3, 32'd0} || lat !== 33) begin
            errors++;
            $display("FAIL restart_after_reset got q=%0d r=%0d lat=%0d want 3/0 lat 33", q, r, lat);
        end
        last_q = 32'd3;
        last_r = 32'd0;
        release_done();
    endtask

    task automatic test_random();
        logic sgn;
        logic [W-1:0] a, b, eq, er, q, r;
        int lat, sc, bc, want_lat, hold;
        for (int i = 0; i < 60; i++) begin
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = 32'd0 - 32'($urandom_range(1, 15));
                default: b = 32'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 20));
                1:       a = 32'h8000_0000;
                default: a = 32'($urandom);
            endcase
            ref_div(sgn, a, b, eq, er);
            want_lat = ref_lat(sgn, a, b);
            do_div(sgn, a, b, q, r, lat, sc, bc);
            checks++;
            if ({q, r} !== {eq, er}) begin
                errors++;
                $display("FAIL rand_%0d s=%b %h/%h got q=%h r=%h want q=%h r=%h", i, sgn, a, b, q, r, eq, er);
            end
            checks++;
            if (lat !== want_lat || sc !== want_lat || bc !== ((want_lat == 1) ? 0 : W)) begin
                errors++;
                $display("FAIL rand_%0d_timing got lat=%0d stop=%0d busy=%0d want lat=%0d", i, lat, sc, bc, want_lat);
            end
            hold = $urandom_range(0, 2);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                checks++;
                if ({div_done, div_quot, div_rem} !== {1'b1, eq, er}) begin
                    errors++;
                    $display("FAIL rand_%0d_hold got done=%b q=%h r=%h want 1 %h/%h", i, div_done, div_quot, div_rem, eq, er);
                end
            end
            last_q = eq;
            last_r = er;
            release_done();
        end
    endtask

    initial begin
        es_div_req = 1'b0;
        es_div_signed = 1'b0;
        es_div_src1 = '0;
        es_div_src2 = '0;
        ms_allowin = 1'b0;
        flush = 1'b0;
        reset = 1'b1;
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
